// File: rtl/vsc_pkg.sv
// Shared types and constants for the VerySimpleCPU boot path.
// State encoding is fixed so the loader state is easy to read on a wave.
package vsc_pkg;

    localparam int WORD_W  = 32;
    localparam int HDR_LEN = 2;

    localparam logic [2:0] S_LEN_HI_C = 3'd0;
    localparam logic [2:0] S_LEN_LO_C = 3'd1;
    localparam logic [2:0] S_DATA_C   = 3'd2;
    localparam logic [2:0] S_CSUM_C   = 3'd3;
    localparam logic [2:0] S_DONE_C   = 3'd4;
    localparam logic [2:0] S_ERR_C    = 3'd5;

    typedef enum logic [2:0] {
        S_LEN_HI = S_LEN_HI_C,
        S_LEN_LO = S_LEN_LO_C,
        S_DATA   = S_DATA_C,
        S_CSUM   = S_CSUM_C,
        S_DONE   = S_DONE_C,
        S_ERR    = S_ERR_C
    } state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs image bytes MSB-first into 32-bit words and keeps a running XOR.
// word/word_valid are combinational on the byte that completes a word.
module boot_word_assembler
    import vsc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_en,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [7:0]        csum
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    logic [7:0]  csum_q;

    assign word       = {shift_q, byte_in};
    assign word_valid = byte_en && (cnt_q == 2'd3);
    assign csum       = csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else if (byte_en) begin
            shift_q <= {shift_q[15:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;
            csum_q  <= csum_q ^ byte_in;
        end
    end

endmodule

// File: rtl/ram_boot_loader.sv
// Loads a length-prefixed, XOR-checked image into blram, holding the CPU
// in reset, then hands the RAM bus over to the CPU.
module ram_boot_loader
    import vsc_pkg::*;
#(
    parameter int SIZE      = 14,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              cpu_wrEn,
    input  logic [SIZE-1:0]   cpu_addr,
    input  logic [WORD_W-1:0] cpu_data,
    output logic              ram_we,
    output logic [SIZE-1:0]   ram_addr,
    output logic [WORD_W-1:0] ram_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam int ROOM = DEPTH - BASE_ADDR;

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q;
    logic [15:0]         len_q;
    logic [15:0]         words_q;
    logic                we_q;
    logic [SIZE-1:0]     addr_q;
    logic [WORD_W-1:0]   data_q;
    logic                ready_q, hold_q, done_q, err_q;

    logic                xfer, asm_en, word_valid, last_word, too_long;
    logic [15:0]         len_full;
    logic [WORD_W-1:0]   word;
    logic [7:0]          csum;

    assign xfer      = s_valid && ready_q;
    assign asm_en    = xfer && (state_q == S_DATA);
    assign len_full  = {len_hi_q, s_data};
    assign too_long  = 32'(len_full) > 32'(ROOM);
    assign last_word = word_valid && (words_q == len_q - 16'd1);

    boot_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (s_data),
        .byte_en    (asm_en),
        .word       (word),
        .word_valid (word_valid),
        .csum       (csum)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (too_long)              state_d = S_ERR;
                    else if (len_full == '0)   state_d = S_CSUM;
                    else                       state_d = S_DATA;
                end
            end
            S_DATA:   if (last_word) state_d = S_CSUM;
            S_CSUM: begin
                if (xfer) state_d = (s_data == csum) ? S_DONE : S_ERR;
            end
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_LEN_HI;
            len_hi_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_DONE) && (state_d != S_ERR);
            we_q    <= word_valid;
            if (xfer && state_q == S_LEN_HI) len_hi_q <= s_data;
            if (xfer && state_q == S_LEN_LO) len_q    <= len_full;
            if (word_valid) begin
                addr_q  <= SIZE'(BASE_ADDR) + SIZE'(words_q);
                data_q  <= word;
                words_q <= words_q + 16'd1;
            end
            if (state_d == S_DONE) begin
                hold_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (state_d == S_ERR) err_q <= 1'b1;
        end
    end

    // The CPU owns the RAM bus only once a verified image is in place.
    assign ram_we       = (state_q == S_DONE) ? cpu_wrEn : we_q;
    assign ram_addr     = (state_q == S_DONE) ? cpu_addr : addr_q;
    assign ram_data     = (state_q == S_DONE) ? cpu_data : data_q;
    assign s_ready      = ready_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench: vector table of whole images plus reset/passthrough
// sequences, with a simple blram model behind each loader instance.
module tb_ram_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        cpu_wrEn = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;

    logic        s_ready0, ram_we0, cpu_hold0, load_done0, load_err0;
    logic [13:0] ram_addr0;
    logic [31:0] ram_data0;
    logic [15:0] words0;
    logic        s_ready1, ram_we1, cpu_hold1, load_done1, load_err1;
    logic [13:0] ram_addr1;
    logic [31:0] ram_data1;
    logic [15:0] words1;

    logic [31:0] mem0 [0:16383];
    logic [31:0] mem1 [0:16383];
    int we0 = 0;
    int we1 = 0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ram_boot_loader #(.SIZE(14), .DEPTH(1024), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .ram_we(ram_we0), .ram_addr(ram_addr0),
        .ram_data(ram_data0), .cpu_hold(cpu_hold0),
        .load_done(load_done0), .load_err(load_err0),
        .words_loaded(words0)
    );

    ram_boot_loader #(.SIZE(14), .DEPTH(1024), .BASE_ADDR(100)) u1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_data(ram_data1), .cpu_hold(cpu_hold1),
        .load_done(load_done1), .load_err(load_err1),
        .words_loaded(words1)
    );

    always @(posedge clk) begin
        if (ram_we0 === 1'b1) begin
            mem0[ram_addr0] <= ram_data0;
            we0 <= we0 + 1;
        end
        if (ram_we1 === 1'b1) begin
            mem1[ram_addr1] <= ram_data1;
            we1 <= we1 + 1;
        end
    end

    typedef struct {
        logic [7:0]  b [11];
        int          n;
        int          gap;
        logic        done;
        logic        err;
        logic        hold;
        int          words;
        int          we;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t v [5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        cpu_wrEn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        for (k = 0; k < 20 && s_ready0 !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        if (s_ready0 !== 1'b1) chk("s_ready_timeout", {31'b0, s_ready0}, 1);
        s_data = b;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] good [11];
        int w0;
        good = '{8'h00, 8'h02, 8'h20, 8'h11, 8'h40, 8'h45,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h34};

        v[0].b = good; v[0].n = 11; v[0].gap = 0;
        v[0].done = 1; v[0].err = 0; v[0].hold = 0;
        v[0].words = 2; v[0].we = 2;
        v[0].r0 = 32'h20114045; v[0].r1 = 32'h0;

        v[1] = v[0]; v[1].b[10] = 8'h35;
        v[1].done = 0; v[1].err = 1; v[1].hold = 1;

        v[2] = v[0]; v[2].b[0] = 8'h04; v[2].b[1] = 8'h01; v[2].n = 2;
        v[2].done = 0; v[2].err = 1; v[2].hold = 1;
        v[2].words = 0; v[2].we = 0;

        v[3] = v[2]; v[3].b[0] = 8'h00; v[3].b[1] = 8'h00;
        v[3].b[2] = 8'h00; v[3].n = 3;
        v[3].done = 1; v[3].err = 0; v[3].hold = 0;

        v[4] = v[0]; v[4].gap = 3;

        // Reset state, sampled while rst is held low.
        #12;
        chk("rst_s_ready", {31'b0, s_ready0}, 0);
        chk("rst_ram_we", {31'b0, ram_we0}, 0);
        chk("rst_ram_addr", {18'b0, ram_addr0}, 0);
        chk("rst_ram_data", ram_data0, 0);
        chk("rst_cpu_hold", {31'b0, cpu_hold0}, 1);
        chk("rst_done_err", {30'b0, load_done0, load_err0}, 0);
        chk("rst_words", {16'b0, words0}, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            w0 = we0;
            for (int j = 0; j < v[i].n; j++) send_byte(v[i].b[j], v[i].gap);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", i), {31'b0, load_done0}, {31'b0, v[i].done});
            chk($sformatf("v%0d_err", i), {31'b0, load_err0}, {31'b0, v[i].err});
            chk($sformatf("v%0d_hold", i), {31'b0, cpu_hold0}, {31'b0, v[i].hold});
            chk($sformatf("v%0d_ready", i), {31'b0, s_ready0}, 0);
            chk($sformatf("v%0d_words", i), {16'b0, words0}, v[i].words);
            chk($sformatf("v%0d_we_pulses", i), we0 - w0, v[i].we);
            if (v[i].we > 0) begin
                chk($sformatf("v%0d_ram0", i), mem0[0], v[i].r0);
                chk($sformatf("v%0d_ram1", i), mem0[1], v[i].r1);
            end
            if (v[i].err) begin
                w0 = we0;
                cpu_wrEn = 1'b1;
                cpu_addr = 14'd50;
                cpu_data = 32'hCAFEF00D;
                #1;
                chk($sformatf("v%0d_no_cpu_we", i), {31'b0, ram_we0}, 0);
                repeat (2) @(posedge clk);
                #1;
                chk($sformatf("v%0d_no_cpu_write", i), we0 - w0, 0);
                cpu_wrEn = 1'b0;
            end
        end

        // Abort a load after six data bytes with a short reset pulse.
        do_reset();
        for (int j = 0; j < 8; j++) send_byte(good[j], 0);
        chk("mid_words_before", {16'b0, words0}, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_words", {16'b0, words0}, 0);
        chk("mid_words_u1", {16'b0, words1}, 0);
        chk("mid_hold", {31'b0, cpu_hold0}, 1);
        chk("mid_ready", {31'b0, s_ready0}, 0);
        chk("mid_ram_we", {31'b0, ram_we0}, 0);
        chk("mid_ram_addr", {18'b0, ram_addr0}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int j = 0; j < 11; j++) send_byte(good[j], 0);
        repeat (2) @(posedge clk);
        #1;
        chk("base100_done", {31'b0, load_done1}, 1);
        chk("base100_ram100", mem1[100], 32'h20114045);
        chk("base100_ram101", mem1[101], 32'h0);
        chk("base100_words", {16'b0, words1}, 2);

        cpu_wrEn = 1'b1;
        cpu_addr = 14'd7;
        cpu_data = 32'hDEADBEEF;
        #1;
        chk("pass_addr7", {18'b0, ram_addr1}, 7);
        chk("pass_we", {31'b0, ram_we1}, 1);
        chk("pass_data", ram_data1, 32'hDEADBEEF);
        cpu_addr = 14'd9;
        cpu_wrEn = 1'b0;
        #1;
        chk("pass_addr9", {18'b0, ram_addr1}, 9);
        chk("pass_we_low", {31'b0, ram_we1}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_boot_loader.md
Name: ram_boot_loader

Overview:
- Upstream stage of the VerySimpleCPU/blram pair. Receives a byte stream after reset and writes a program image into blram as 32-bit words, starting at BASE_ADDR.
- Holds the CPU in reset while loading.
- After a valid image, hands the RAM write/address bus to the CPU through a built-in mux.
- data_fromRAM goes directly from RAM to CPU and does not pass through this block.

Parameters:
SIZE, 14, RAM address width (matches blram i_addr).
DEPTH, 1024, RAM depth in words.
BASE_ADDR, 0, first RAM word address written.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
s_data  input  8  incoming image byte.
s_valid  input  1  s_data valid.
s_ready  output  1  loader accepts byte; transfer = s_valid & s_ready.
cpu_wrEn  input  1  CPU write enable.
cpu_addr  input  SIZE  CPU address.
cpu_data  input  32  CPU write data.
ram_we  output  1  to blram i_we.
ram_addr  output  SIZE  to blram i_addr.
ram_data  output  32  to blram i_ram_data_in.
cpu_hold  output  1  active-high; drives CPU rst.
load_done  output  1  image loaded and checksum good.
load_err  output  1  length overflow or checksum mismatch.
words_loaded  output  16  count of words written.

Behaviour:
- Image format:
  - LEN_HI, LEN_LO: word count N, 16-bit, big-endian.
  - N×4 data bytes: each word big-endian, MSB first.
  - CSUM: XOR of all 4N data bytes. Length bytes are excluded from the XOR.
- FSM states: S_LEN_HI → S_LEN_LO → S_DATA → S_CSUM → S_DONE | S_ERR. Every transition advances only on an accepted byte.
- Reset (rst=0, asynchronous):
  - State is S_LEN_HI.
  - s_ready=0, ram_we=0, ram_addr=0, ram_data=0.
  - cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
  - Byte counter, XOR accumulator and address counter are cleared.
- After rst release, s_ready=1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM. s_ready=0 in S_DONE and S_ERR.
- S_LEN_LO with N > DEPTH-BASE_ADDR: go to S_ERR.
- S_LEN_LO with N=0: go directly to S_CSUM; the expected checksum is 0x00.
- S_DATA byte handling:
  - Bytes shift into a 32-bit assembly register, MSB first.
  - On the 4th byte of a word, the next cycle registers ram_we=1 for exactly one cycle, ram_addr=BASE_ADDR+word index, ram_data=assembled word.
  - words_loaded increments in that same cycle.
  - After word N, go to S_CSUM.
- S_CSUM: the accepted byte is compared with the accumulator. Equal → S_DONE, otherwise → S_ERR.
- Write ordering: the last RAM write always completes before S_DONE, because the checksum byte arrives at least one cycle after the 4th byte of the last word.
- Bus mux:
  - In S_DONE: ram_we, ram_addr and ram_data are a combinational pass-through of cpu_wrEn, cpu_addr and cpu_data.
  - In all other states, the loader's registered signals drive the RAM bus.
- cpu_hold and status:
  - cpu_hold is registered. It goes to 0 on the edge that enters S_DONE, and stays 1 in S_ERR.
  - load_done and load_err are registered and sticky until reset.
- S_DONE and S_ERR are terminal; only reset leaves them.
- s_valid gaps: any number of idle cycles between bytes is legal; the state is held.
- Reset mid-load: abandons the image.
  - Words already written stay in RAM; no scrub.
  - Reloading overwrites from BASE_ADDR.
- Address width: ram_addr = (BASE_ADDR + index) truncated to SIZE bits. No wrap can occur because N is bounded.
- words_loaded saturates naturally: N ≤ DEPTH ≤ 65535.

Decomposition:
- Shared package vsc_pkg:
  - State encoding localparams: S_LEN_HI=0, S_LEN_LO=1, S_DATA=2, S_CSUM=3, S_DONE=4, S_ERR=5.
  - Word width 32.
  - Header length 2.
- One sub-module, boot_word_assembler: byte shift register, 2-bit byte counter, XOR accumulator, word_valid strobe.
- The FSM, address counter and bus mux stay in ram_boot_loader.

Test Plan:
- Good image: bytes 00 02 | 20 11 40 45 | 00 00 00 00 | 34.
  - RAM[0]=0x20114045, RAM[1]=0.
  - ram_we pulses twice, words_loaded=2.
  - load_done=1, cpu_hold=0, s_ready=0.
- Bad checksum: same image with csum 0x35.
  - load_err=1, cpu_hold stays 1.
  - cpu_wrEn=1, cpu_addr=50 produces no write.
- Length overflow: header 04 01 (N=1025, DEPTH=1024).
  - S_ERR right after LEN_LO, no ram_we pulse, load_err=1.
- Empty image: 00 00 00.
  - load_done=1, words_loaded=0, no RAM writes.
- Throttled input: good image with s_valid low for 3 cycles between every byte.
  - Same final RAM and status as the good-image case.
- Reset mid-load: drop rst for 1 cycle after 6 data bytes.
  - Outputs return to reset values immediately.
  - A following good image with BASE_ADDR=100 writes RAM[100], RAM[101].
  - Passthrough then follows cpu_addr.
